// File: rtl/serial_status_ctrl_if.sv
// serial_status_ctrl_if: event inputs and status/debug outputs of the serial link status sequencer
interface serial_status_ctrl_if;
  logic       req_sent;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       clear_err;
  logic       wait_o;
  logic       error_o;
  logic       reset_o;
  logic [1:0] err_code;
  logic [7:0] err_count;
  modport master (
    output req_sent, rx_valid, rx_frame_err, clear_err,
    input  wait_o, error_o, reset_o, err_code, err_count
  );
  modport slave (
    input  req_sent, rx_valid, rx_frame_err, clear_err,
    output wait_o, error_o, reset_o, err_code, err_count
  );
endinterface

// File: rtl/serial_status_ctrl.sv
// serial_status_ctrl: boot/wait/error status sequencer driving the RGB LED flags, with error cause and counter
module serial_status_ctrl #(
  parameter int BOOT_CYCLES     = 12_500_000,
  parameter int TIMEOUT_CYCLES  = 50_000_000,
  parameter int ERR_HOLD_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  serial_status_ctrl_if.slave bus
);
  localparam int MAXC  = (BOOT_CYCLES > TIMEOUT_CYCLES)
                       ? ((BOOT_CYCLES > ERR_HOLD_CYCLES) ? BOOT_CYCLES : ERR_HOLD_CYCLES)
                       : ((TIMEOUT_CYCLES > ERR_HOLD_CYCLES) ? TIMEOUT_CYCLES : ERR_HOLD_CYCLES);
  localparam int CNT_W = $clog2(MAXC) + 1;
  localparam logic [CNT_W-1:0] BOOT_END = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_END   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(ERR_HOLD_CYCLES - 1);
  typedef enum logic [1:0] {BOOT, IDLE, WAIT_RESP, ERROR} state_t;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       code, code_n;
  logic [7:0]       count, count_n;
  always_ff @(posedge clk)
    if (reset) begin
      state <= BOOT;
      cnt   <= '0;
      code  <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      code  <= code_n;
      count <= count_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    code_n  = code;
    count_n = count;
    case (state)
      BOOT:
        if (bus.rx_frame_err) begin
          state_n = ERROR;
          code_n  = 2'b01;
        end else if (cnt == BOOT_END) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      IDLE: begin
        cnt_n = '0;
        if (bus.rx_frame_err) begin
          state_n = ERROR;
          code_n  = 2'b01;
        end else if (bus.req_sent) state_n = WAIT_RESP;
      end
      WAIT_RESP:
        if (bus.rx_frame_err) begin
          state_n = ERROR;
          code_n  = 2'b01;
        end else if (bus.rx_valid) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == TO_END) begin
          state_n = ERROR;
          code_n  = 2'b10;
        end else if (bus.req_sent) cnt_n = '0;
      ERROR:
        if (bus.clear_err || (!bus.rx_frame_err && cnt == HOLD_END)) begin
          state_n = IDLE;
          cnt_n   = '0;
          code_n  = '0;
        end else if (bus.rx_frame_err) begin
          cnt_n  = '0;
          code_n = code | 2'b01;
        end
    endcase
    // Only a fresh entry counts; a repeat frame error inside ERROR just restarts the hold
    if (state != ERROR && state_n == ERROR) begin
      cnt_n   = '0;
      count_n = count + 8'(count != 8'hff);
    end
  end
  assign bus.reset_o   = state == BOOT;
  assign bus.wait_o    = state == WAIT_RESP;
  assign bus.error_o   = state == ERROR;
  assign bus.err_code  = code;
  assign bus.err_count = count;
endmodule

// File: doc/serial_status_ctrl.md
Name: serial_status_ctrl

Overview:
Status sequencer for the serial link. It watches UART receive events and request/response timing, and produces the three mutually exclusive indicator flags (wait, error, reset) that feed the RGB status LED driver directly. It also latches an error cause code and a saturating error counter for debug readout.

Parameters:
BOOT_CYCLES, 12_500_000, cycles reset_o stays high after reset release (min 1)
TIMEOUT_CYCLES, 50_000_000, max cycles in WAIT_RESP before timeout error (min 1)
ERR_HOLD_CYCLES, 25_000_000, cycles error_o is held before auto-return to IDLE (min 1)
CNT_W, $clog2(max of the three)+1, internal cycle counter width (derived)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req_sent  input  1  1-cycle pulse: command transmitted, response expected
rx_valid  input  1  1-cycle pulse: byte received without error
rx_frame_err  input  1  1-cycle pulse: UART framing/stop-bit error
clear_err  input  1  level: software/button acknowledge of error
wait_o  output  1  waiting for response (to LED driver WAIT)
error_o  output  1  error indication (to LED driver error)
reset_o  output  1  post-reset indication (to LED driver reset)
err_code  output  2  bit0 = frame error seen, bit1 = timeout seen; valid while error_o=1
err_count  output  8  number of ERROR-state entries, saturates at 255

Behaviour:
- reset: synchronous, active-high; overrides everything. state=BOOT, cnt=0, err_code=0, err_count=0, so reset_o=1, wait_o=0, error_o=0.
- Moore outputs, decoded from registered state: reset_o=(BOOT), wait_o=(WAIT_RESP), error_o=(ERROR). Exactly one or none is high.
- Latency: outputs change in the cycle after the triggering input is sampled.
- BOOT:
  - cnt increments each cycle; at cnt==BOOT_CYCLES-1 go to IDLE with cnt=0, so reset_o is high for exactly BOOT_CYCLES cycles.
  - rx_frame_err goes to ERROR (err_code=01). req_sent is ignored.
- IDLE:
  - All flags 0. rx_frame_err goes to ERROR (err_code=01).
  - Otherwise req_sent goes to WAIT_RESP with cnt=0. rx_valid alone is ignored.
- WAIT_RESP, evaluated in priority order:
  1. rx_frame_err: go to ERROR, err_code=01.
  2. rx_valid: go to IDLE. A response on the timeout cycle still counts as success.
  3. cnt==TIMEOUT_CYCLES-1: go to ERROR, err_code=10. wait_o is therefore high for at most TIMEOUT_CYCLES cycles.
  4. req_sent: cnt=0 (timeout restarts).
  5. Otherwise cnt++.
- ERROR:
  - Entry: cnt=0 and err_count increments, saturating at 255.
  - clear_err=1 (highest priority): go to IDLE, err_code=0.
  - rx_frame_err: cnt=0 and err_code[0] is set; sticky OR, no new err_count increment.
  - cnt==ERR_HOLD_CYCLES-1: go to IDLE, err_code=0.
  - Otherwise cnt++. req_sent and rx_valid are ignored.
- clear_err outside ERROR: no effect.
- err_code is held stable for the whole ERROR residency and reads 0 in all other states.
- Reset mid-operation (any state): next cycle is BOOT with all registers at reset values, including err_count.
- The counter never wraps: every state exits or reloads before cnt reaches its terminal value.

Test Plan:
(Bench parameters: BOOT_CYCLES=3, TIMEOUT_CYCLES=8, ERR_HOLD_CYCLES=4.)
1. Reset held 2 cycles, then released -> reset_o=1 for exactly 3 cycles after release, then all flags 0; err_count=0, err_code=0.
2. IDLE, req_sent pulse, rx_valid 5 cycles later -> wait_o=1 for 5 cycles, then all 0; err_count stays 0.
3. IDLE, req_sent, no response -> wait_o=1 for 8 cycles, then error_o=1 with err_code=10 for 4 cycles, then IDLE; err_count=1.
4. WAIT_RESP, rx_valid and rx_frame_err in the same cycle -> ERROR with err_code=01. A second rx_frame_err 2 cycles into ERROR -> hold restarts, error_o lasts 6 cycles total, err_count increments once only.
5. ERROR entered, clear_err asserted on the 2nd ERROR cycle -> next cycle error_o=0, err_code=00, state IDLE. rx_valid arriving on the exact timeout cycle of WAIT_RESP -> IDLE, no error.
6. 300 forced timeouts -> err_count saturates at 255. Reset asserted mid-WAIT_RESP -> next cycle reset_o=1, wait_o=0, err_count=0.
